bram0_packer: RTL and testbench
===============================

BRAM0_PACKER -- requirements
Module: bram0_packer

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 8, the BRAM0 address width.
REQ-002 The block SHALL have parameter DWIDTH, default 32, the BRAM0 row width (4 bytes).
REQ-003 The block SHALL have parameter IN_DATA_WIDTH, default 8, the byte width.
REQ-004 Port clk, input, 1: clock; all logic is rising-edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port start_i, input, 1: start pulse, sampled only in IDLE.
REQ-007 Port row_count_i, input, AWIDTH+1: number of BRAM0 rows to fill, sampled with start_i.
REQ-008 Ports s_valid_i / s_data_i / s_last_i, input, 1 / IN_DATA_WIDTH / 1: byte stream valid, data, and last-byte flag.
REQ-009 Port s_ready_o, output, 1: byte stream ready.
REQ-010 Ports addr_o / ce_o / we_o / d_o, output, AWIDTH / 1 / 1 / DWIDTH: BRAM0 write port.
REQ-011 Ports idle_o / run_o / done_o, output, 1 each: state flags.
REQ-012 Port rows_written_o, output, AWIDTH+1: count of rows written in the current or last job.
REQ-013 Port checksum_o, output, 16: modulo-2^16 sum of the accepted bytes.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN, LAST and DONE, one-hot decoded onto idle_o (IDLE), run_o (RUN or LAST) and done_o (DONE).
REQ-015 IDLE: on start_i=1 with row_count_i!=0, the FSM SHALL latch row_count_i, clear rows_written_o, checksum_o and the byte index, and go to RUN.
REQ-016 IDLE: on start_i=1 with row_count_i=0, the FSM SHALL go directly to DONE and issue no writes.
REQ-017 s_ready_o SHALL be 1 only in RUN, combinationally from state, with no dependence on s_valid_i.
REQ-018 A byte is accepted when s_valid_i & s_ready_o; byte k (k=0..3) of a row SHALL land in d_o bits [8k+7:8k], so byte 0 is the LSB.
REQ-019 On the cycle after a row's 4th byte is accepted, the block SHALL pulse ce_o=we_o=1 for exactly one cycle, with d_o = the packed row and addr_o = the row index.
REQ-020 Row index SHALL start at 0 and increment by 1 per write, with no wrap within a job.
REQ-021 Throughput SHALL be 1 byte per cycle; the row write and acceptance of the next row's byte 0 may occur in the same cycle.
REQ-022 When the 4th byte of row row_count-1 is accepted, the FSM SHALL go RUN->LAST; LAST performs that final write, then goes to DONE.
REQ-023 If s_last_i is accepted on byte k<3, the remaining bytes SHALL be zero-padded, that row written, and the FSM go RUN->LAST->DONE.
REQ-024 If s_last_i is accepted on byte 3, the row SHALL be written normally and the FSM go RUN->LAST->DONE.
REQ-025 DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE.
REQ-026 start_i outside IDLE SHALL be ignored.
REQ-027 ce_o and we_o SHALL be 0 in every cycle other than a write pulse.
REQ-028 rows_written_o SHALL increment with each write pulse and hold through DONE/IDLE until the next accepted start.
REQ-029 Bytes presented while s_ready_o=0 SHALL NOT be consumed or counted.

Reset
REQ-030 While reset_n=0, state SHALL be IDLE, and s_ready_o, ce_o, we_o, addr_o, d_o, run_o, done_o, rows_written_o and checksum_o SHALL all be 0, with idle_o=1.
REQ-031 Reset mid-job SHALL discard any partial row with no write, and the block SHALL wait for a new start_i.

Configuration
REQ-032 With macro BRAM0_PACKER_CHECKSUM_EN defined, checksum_o SHALL add each accepted byte (zero-extended, modulo 2^16), cleared on an accepted start; pad bytes are excluded.
REQ-033 Without BRAM0_PACKER_CHECKSUM_EN, checksum_o SHALL be constant 0 and no checksum register SHALL be synthesized.

Structure
REQ-034 A shared package bram_pkg SHALL hold the FSM state encoding (IDLE/RUN/LAST/DONE) and the default constants AWIDTH=8, DWIDTH=32, IN_DATA_WIDTH=8, MEM_SIZE=256.
REQ-035 The byte-to-row shift/pack register SHALL be one sub-module, byte_packer (inputs: byte valid, data, last; outputs: row-ready pulse, packed row); the FSM, counters and checksum stay in the top.

Verification
REQ-036 Scenario: row_count=2, bytes 01..08 back-to-back -> writes addr0=0x04030201, addr1=0x08070605 on consecutive rows, done pulse 1 cycle after the last write, rows_written=2.
REQ-037 Scenario: row_count=3, s_last on 6th byte (bytes 11..16) -> addr0=0x14131211, addr1=0x00001615, then DONE, rows_written=2, no 3rd write.
REQ-038 Scenario: row_count=0 with start -> DONE next cycle, s_ready never 1, ce never 1.
REQ-039 Scenario: row_count=1, s_valid toggling every other cycle -> single write 0xDDCCBBAA for bytes AA,BB,CC,DD; idle bytes not consumed.
REQ-040 Scenario: reset_n low after 2 bytes of row 0 -> no write, idle_o=1; a new start with row_count=1 and bytes 01..04 -> addr0=0x04030201.
REQ-041 Scenario (BRAM0_PACKER_CHECKSUM_EN): bytes FF x8, row_count=2 -> checksum_o=0x07F8; without the macro, checksum_o=0.

Source files
------------

// File: rtl/bram_pkg.sv
// ---------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the BRAM0 byte packer:
//   state_e             - packer FSM state encoding (IDLE/RUN/LAST/DONE)
//   BRAM_AWIDTH         - default BRAM0 address width
//   BRAM_DWIDTH         - default BRAM0 row width (4 bytes)
//   BRAM_IN_DATA_WIDTH  - default byte width
//   MEM_SIZE            - BRAM0 depth in rows
// ---------------------------------------------------------------------------
package bram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int BRAM_AWIDTH        = 8;
  localparam int BRAM_DWIDTH        = 32;
  localparam int BRAM_IN_DATA_WIDTH = 8;
  localparam int MEM_SIZE           = 256;

endpackage

// File: rtl/bram0_packer_if.sv
// ---------------------------------------------------------------------------
// bram0_packer_if
// Byte-stream handshake into the BRAM0 packer.
//   s_valid - byte valid (source -> packer)
//   s_data  - byte value (source -> packer)
//   s_last  - last byte of the stream (source -> packer)
//   s_ready - packer can take a byte (packer -> source)
// Modports: master = byte source, slave = packer.
// ---------------------------------------------------------------------------
interface bram0_packer_if #(
  parameter int IN_DATA_WIDTH = 8
);

  logic                     s_valid;
  logic [IN_DATA_WIDTH-1:0] s_data;
  logic                     s_last;
  logic                     s_ready;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Collects accepted bytes into a DWIDTH-wide row, byte 0 in the LSBs.
// A row closes on its last byte slot or on a last-flagged byte; unused
// upper slots are zero. The packed row is presented one cycle later with a
// single-cycle row_vld_o pulse.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   clear_i      - drop any partial row and restart at byte slot 0
//   vld_i        - byte accepted this cycle
//   data_i       - accepted byte
//   last_i       - accepted byte is the final one of the stream
//   fill_o       - this cycle's accepted byte closes the row (combinational)
//   row_vld_o    - packed row valid pulse (registered)
//   row_o        - packed row (registered)
// ---------------------------------------------------------------------------
module byte_packer #(
  parameter int DWIDTH        = 32,
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear_i,
  input  logic                     vld_i,
  input  logic [IN_DATA_WIDTH-1:0] data_i,
  input  logic                     last_i,
  output logic                     fill_o,
  output logic                     row_vld_o,
  output logic [DWIDTH-1:0]        row_o
);

  localparam int NBYTES = DWIDTH / IN_DATA_WIDTH;
  localparam int IDXW   = $clog2(NBYTES);

  logic [IDXW-1:0]   idx_q;
  logic [DWIDTH-1:0] acc_q;
  logic [DWIDTH-1:0] acc_d;
  logic [DWIDTH-1:0] row_q;
  logic              row_vld_q;

  assign fill_o = vld_i & (last_i | (idx_q == IDXW'(NBYTES - 1)));

  // Slots above the current index are still zero in acc_q, which gives the
  // zero padding of a short final row for free.
  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx_q == IDXW'(k)) begin
        acc_d[k*IN_DATA_WIDTH +: IN_DATA_WIDTH] = data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q     <= '0;
      acc_q     <= '0;
      row_q     <= '0;
      row_vld_q <= 1'b0;
    end else begin
      row_vld_q <= 1'b0;
      if (clear_i) begin
        idx_q <= '0;
        acc_q <= '0;
      end else if (vld_i) begin
        if (fill_o) begin
          row_q     <= acc_d;
          row_vld_q <= 1'b1;
          idx_q     <= '0;
          acc_q     <= '0;
        end else begin
          acc_q <= acc_d;
          idx_q <= idx_q + IDXW'(1);
        end
      end
    end
  end

  assign row_vld_o = row_vld_q;
  assign row_o     = row_q;

endmodule

// File: rtl/bram0_packer.sv
// ---------------------------------------------------------------------------
// bram0_packer
// Packs a byte stream into BRAM0 rows and writes them at consecutive
// addresses starting from 0, for row_count_i rows or until s_last.
// Optional feature: define BRAM0_PACKER_CHECKSUM_EN to get a modulo-2^16
// sum of accepted bytes on checksum_o (otherwise checksum_o is tied to 0).
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   start_i          - start a job (only looked at in IDLE)
//   row_count_i      - rows to fill, sampled with start_i
//   s_if (slave)     - byte stream s_valid/s_data/s_last/s_ready
//   addr_o/ce_o/we_o/d_o - BRAM0 write port
//   idle_o/run_o/done_o  - state flags
//   rows_written_o   - rows written in the current/last job
//   checksum_o       - byte checksum (0 unless BRAM0_PACKER_CHECKSUM_EN)
// ---------------------------------------------------------------------------
module bram0_packer
  import bram_pkg::*;
#(
  parameter int AWIDTH        = BRAM_AWIDTH,
  parameter int DWIDTH        = BRAM_DWIDTH,
  parameter int IN_DATA_WIDTH = BRAM_IN_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [AWIDTH:0]   row_count_i,
  bram0_packer_if.slave     s_if,
  output logic [AWIDTH-1:0] addr_o,
  output logic              ce_o,
  output logic              we_o,
  output logic [DWIDTH-1:0] d_o,
  output logic              idle_o,
  output logic              run_o,
  output logic              done_o,
  output logic [AWIDTH:0]   rows_written_o,
  output logic [15:0]       checksum_o
);

  state_e            state_q;
  logic [AWIDTH:0]   row_count_q;
  logic [AWIDTH:0]   rows_written_q;
  logic              start_acc;
  logic              byte_acc;
  logic              row_fill;
  logic              row_vld;
  logic [DWIDTH-1:0] row_data;
  logic              final_row;

  assign s_if.s_ready = (state_q == RUN);
  assign byte_acc     = s_if.s_valid & s_if.s_ready;
  assign start_acc    = start_i & (state_q == IDLE);

  // The previous row's write always lands before this row can close, so
  // rows_written_q already counts every earlier row here.
  assign final_row = s_if.s_last | ((rows_written_q + (AWIDTH+1)'(1)) == row_count_q);

  byte_packer #(
    .DWIDTH        (DWIDTH),
    .IN_DATA_WIDTH (IN_DATA_WIDTH)
  ) u_byte_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (start_acc),
    .vld_i     (byte_acc),
    .data_i    (s_if.s_data),
    .last_i    (s_if.s_last),
    .fill_o    (row_fill),
    .row_vld_o (row_vld),
    .row_o     (row_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      row_count_q    <= '0;
      rows_written_q <= '0;
    end else begin
      if (row_vld) begin
        rows_written_q <= rows_written_q + (AWIDTH+1)'(1);
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            row_count_q    <= row_count_i;
            rows_written_q <= '0;
            state_q        <= (row_count_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (row_fill && final_row) begin
            state_q <= LAST;
          end
        end
        // The final row's write pulse occurs during LAST.
        LAST:    state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ce_o           = row_vld;
  assign we_o           = row_vld;
  assign d_o            = row_data;
  assign addr_o         = rows_written_q[AWIDTH-1:0];
  assign rows_written_o = rows_written_q;
  assign idle_o         = (state_q == IDLE);
  assign run_o          = (state_q == RUN) | (state_q == LAST);
  assign done_o         = (state_q == DONE);

`ifdef BRAM0_PACKER_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= '0;
    end else if (start_acc) begin
      checksum_q <= '0;
    end else if (byte_acc) begin
      checksum_q <= checksum_q + 16'(s_if.s_data);
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = 16'h0000;
`endif

endmodule

// File: tb/tb_bram0_packer.sv
// ---------------------------------------------------------------------------
// tb_bram0_packer
// Directed bench for bram0_packer: reset state, back-to-back packing,
// early s_last padding, zero-row job, sparse valid, checksum with start
// ignored mid-job, and reset in the middle of a row.
// ---------------------------------------------------------------------------
module tb_bram0_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i;
  logic [8:0]  row_count_i;
  logic [7:0]  addr_o;
  logic        ce_o;
  logic        we_o;
  logic [31:0] d_o;
  logic        idle_o;
  logic        run_o;
  logic        done_o;
  logic [8:0]  rows_written_o;
  logic [15:0] checksum_o;

  int tests = 0;
  int fails = 0;

  bram0_packer_if #(.IN_DATA_WIDTH(8)) s_if ();

  bram0_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_i        (start_i),
    .row_count_i    (row_count_i),
    .s_if           (s_if),
    .addr_o         (addr_o),
    .ce_o           (ce_o),
    .we_o           (we_o),
    .d_o            (d_o),
    .idle_o         (idle_o),
    .run_o          (run_o),
    .done_o         (done_o),
    .rows_written_o (rows_written_o),
    .checksum_o     (checksum_o)
  );

  always #5 clk = ~clk;

  // Write/flag monitor, sampled on the falling edge.
  int          cyc = 0;
  int          ready_cnt = 0;
  int          cewe_bad = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (s_if.s_ready === 1'b1) ready_cnt++;
    if (ce_o !== we_o) cewe_bad++;
    if (ce_o === 1'b1) begin
      wr_addr.push_back(addr_o);
      wr_data.push_back(d_o);
      wr_cyc.push_back(cyc);
    end
    if (done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic do_start(input logic [8:0] cnt, output int scyc);
    start_i     = 1'b1;
    row_count_i = cnt;
    @(posedge clk); #1;
    start_i     = 1'b0;
    scyc        = cyc;
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    int n = 0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = b;
    s_if.s_last  = l;
    while (s_if.s_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL send_ready: s_ready stayed %b, required 1", s_if.s_ready);
    end
    @(posedge clk); #1;
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n >= 40) begin
      fails++;
      $display("FAIL %s_done_timeout: done_o not seen in %0d cycles, required pulse", tag, n);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (idle_o !== 1'b1 || run_o !== 1'b0 || done_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: idle/run/done=%b%b%b, required 100", idle_o, run_o, done_o);
    end
    tests++;
    if (s_if.s_ready !== 1'b0 || ce_o !== 1'b0 || we_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ready/ce/we=%b%b%b, required 000", s_if.s_ready, ce_o, we_o);
    end
    tests++;
    if (addr_o !== 8'h00 || d_o !== 32'h0 || rows_written_o !== 9'd0 || checksum_o !== 16'h0) begin
      fails++;
      $display("FAIL reset_data: addr=%h d=%h rows=%0d cks=%h, required all 0",
               addr_o, d_o, rows_written_o, checksum_o);
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    int s;
    int d0;
    clear_log();
    d0 = done_cnt;
    do_start(9'd2, s);
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    wait_done("b2b");
    tests++;
    if (wr_addr.size() != 2) begin
      fails++;
      $display("FAIL b2b_count: %0d writes, required 2", wr_addr.size());
    end else begin
      tests++;
      if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h04030201) begin
        fails++;
        $display("FAIL b2b_row0: addr=%h d=%h, required 00 04030201", wr_addr[0], wr_data[0]);
      end
      tests++;
      if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h08070605) begin
        fails++;
        $display("FAIL b2b_row1: addr=%h d=%h, required 01 08070605", wr_addr[1], wr_data[1]);
      end
      tests++;
      if (wr_cyc[1] - wr_cyc[0] != 4) begin
        fails++;
        $display("FAIL b2b_spacing: %0d cycles between writes, required 4", wr_cyc[1] - wr_cyc[0]);
      end
      tests++;
      if (done_cyc != wr_cyc[1] + 1) begin
        fails++;
        $display("FAIL b2b_done_lat: done at %0d, required %0d", done_cyc, wr_cyc[1] + 1);
      end
    end
    idle_cycles(3);
    tests++;
    if (rows_written_o !== 9'd2 || idle_o !== 1'b1 || done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL b2b_end: rows=%0d idle=%b dones=%0d, required 2 1 1",
               rows_written_o, idle_o, done_cnt - d0);
    end
  endtask

  task automatic test_early_last();
    int s;
    clear_log();
    do_start(9'd3, s);
    for (int i = 0; i < 5; i++) send(8'(8'h11 + i), 1'b0);
    send(8'h16, 1'b1);
    wait_done("last");
    idle_cycles(5);
    tests++;
    if (wr_addr.size() != 2) begin
      fails++;
      $display("FAIL last_count: %0d writes, required 2", wr_addr.size());
    end else begin
      tests++;
      if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h14131211) begin
        fails++;
        $display("FAIL last_row0: addr=%h d=%h, required 00 14131211", wr_addr[0], wr_data[0]);
      end
      tests++;
      if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h00001615) begin
        fails++;
        $display("FAIL last_row1: addr=%h d=%h, required 01 00001615", wr_addr[1], wr_data[1]);
      end
    end
    tests++;
    if (rows_written_o !== 9'd2 || idle_o !== 1'b1) begin
      fails++;
      $display("FAIL last_end: rows=%0d idle=%b, required 2 1", rows_written_o, idle_o);
    end
  endtask

  task automatic test_zero_rows();
    int s;
    int r0;
    clear_log();
    r0 = ready_cnt;
    do_start(9'd0, s);
    wait_done("zero");
    idle_cycles(3);
    tests++;
    if (done_cyc != s) begin
      fails++;
      $display("FAIL zero_done_lat: done at %0d, required %0d", done_cyc, s);
    end
    tests++;
    if (ready_cnt != r0 || wr_addr.size() != 0) begin
      fails++;
      $display("FAIL zero_activity: ready cycles=%0d writes=%0d, required 0 0",
               ready_cnt - r0, wr_addr.size());
    end
    tests++;
    if (idle_o !== 1'b1) begin
      fails++;
      $display("FAIL zero_idle: idle=%b, required 1", idle_o);
    end
  endtask

  task automatic test_sparse_valid();
    int s;
    logic [7:0] b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    clear_log();
    do_start(9'd1, s);
    for (int i = 0; i < 4; i++) begin
      send(b[i], 1'b0);
      // Junk on the bus with valid low must be ignored.
      s_if.s_data = 8'hEE;
      s_if.s_last = 1'b1;
      idle_cycles(1);
      s_if.s_last = 1'b0;
    end
    wait_done("sparse");
    idle_cycles(2);
    tests++;
    if (wr_addr.size() != 1) begin
      fails++;
      $display("FAIL sparse_count: %0d writes, required 1", wr_addr.size());
    end else begin
      tests++;
      if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'hDDCCBBAA) begin
        fails++;
        $display("FAIL sparse_row0: addr=%h d=%h, required 00 DDCCBBAA", wr_addr[0], wr_data[0]);
      end
    end
    tests++;
    if (rows_written_o !== 9'd1) begin
      fails++;
      $display("FAIL sparse_rows: rows=%0d, required 1", rows_written_o);
    end
  endtask

  task automatic test_checksum();
    int s;
    logic [15:0] exp_cks;
`ifdef BRAM0_PACKER_CHECKSUM_EN
    exp_cks = 16'h07F8;
`else
    exp_cks = 16'h0000;
`endif
    clear_log();
    do_start(9'd2, s);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        start_i     = 1'b1;
        row_count_i = 9'd1;
      end
      send(8'hFF, 1'b0);
      start_i = 1'b0;
    end
    wait_done("cks");
    idle_cycles(3);
    tests++;
    if (wr_addr.size() != 2) begin
      fails++;
      $display("FAIL cks_count: %0d writes, required 2", wr_addr.size());
    end else begin
      tests++;
      if (wr_data[0] !== 32'hFFFFFFFF || wr_data[1] !== 32'hFFFFFFFF || wr_addr[1] !== 8'd1) begin
        fails++;
        $display("FAIL cks_rows: d0=%h d1=%h a1=%h, required FFFFFFFF FFFFFFFF 01",
                 wr_data[0], wr_data[1], wr_addr[1]);
      end
    end
    tests++;
    if (checksum_o !== exp_cks) begin
      fails++;
      $display("FAIL cks_value: checksum=%h, required %h", checksum_o, exp_cks);
    end
    tests++;
    if (rows_written_o !== 9'd2 || idle_o !== 1'b1) begin
      fails++;
      $display("FAIL cks_hold: rows=%0d idle=%b, required 2 1", rows_written_o, idle_o);
    end
  endtask

  task automatic test_reset_mid_job();
    int s;
    clear_log();
    do_start(9'd1, s);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    reset_n = 1'b0;
    #1;
    tests++;
    if (idle_o !== 1'b1 || run_o !== 1'b0 || s_if.s_ready !== 1'b0 || ce_o !== 1'b0 ||
        d_o !== 32'h0 || rows_written_o !== 9'd0 || checksum_o !== 16'h0) begin
      fails++;
      $display("FAIL midrst_state: idle=%b run=%b rdy=%b ce=%b d=%h rows=%0d cks=%h, required 1 0 0 0 0 0 0",
               idle_o, run_o, s_if.s_ready, ce_o, d_o, rows_written_o, checksum_o);
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycles(3);
    tests++;
    if (wr_addr.size() != 0 || idle_o !== 1'b1) begin
      fails++;
      $display("FAIL midrst_nowrite: writes=%0d idle=%b, required 0 1", wr_addr.size(), idle_o);
    end
    do_start(9'd1, s);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    wait_done("midrst");
    idle_cycles(2);
    tests++;
    if (wr_addr.size() != 1) begin
      fails++;
      $display("FAIL midrst_count: %0d writes, required 1", wr_addr.size());
    end else begin
      tests++;
      if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h04030201) begin
        fails++;
        $display("FAIL midrst_row0: addr=%h d=%h, required 00 04030201", wr_addr[0], wr_data[0]);
      end
    end
    tests++;
    if (cewe_bad != 0) begin
      fails++;
      $display("FAIL ce_we_match: %0d cycles with ce!=we, required 0", cewe_bad);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    start_i      = 1'b0;
    row_count_i  = '0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    s_if.s_last  = 1'b0;
    test_reset();
    test_back_to_back();
    test_early_last();
    test_zero_rows();
    test_sparse_valid();
    test_checksum();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
